// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receiver and baud generator.
//   rx_state_e    : receiver FSM states
//   BAUD_*        : baud_select rate codes
//   DIV_W         : width of the baud divisor counter
//   baud_rate()   : rate in baud for a code
//   baud_divisor(): clocks per sample tick (16 ticks per bit), rounded
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic [2:0] BAUD_300    = 3'd0;
  localparam logic [2:0] BAUD_1200   = 3'd1;
  localparam logic [2:0] BAUD_4800   = 3'd2;
  localparam logic [2:0] BAUD_9600   = 3'd3;
  localparam logic [2:0] BAUD_19200  = 3'd4;
  localparam logic [2:0] BAUD_38400  = 3'd5;
  localparam logic [2:0] BAUD_57600  = 3'd6;
  localparam logic [2:0] BAUD_115200 = 3'd7;

  localparam int DIV_W = 24;

  function automatic int unsigned baud_rate(input logic [2:0] code);
    case (code)
      BAUD_300:    return 300;
      BAUD_1200:   return 1200;
      BAUD_4800:   return 4800;
      BAUD_9600:   return 9600;
      BAUD_19200:  return 19200;
      BAUD_38400:  return 38400;
      BAUD_57600:  return 57600;
      default:     return 115200;
    endcase
  endfunction

  // round(clk_hz / (16 * rate)), never below 1 so the counter always wraps
  function automatic int unsigned baud_divisor(input int unsigned clk_hz,
                                               input logic [2:0]  code);
    int unsigned rate;
    int unsigned div;
    rate = baud_rate(code);
    div  = (clk_hz + 8 * rate) / (16 * rate);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/baud_controller.sv
// baud_controller -- sample-tick generator, 16 ticks per bit.
//   clk         : system clock
//   reset       : synchronous active-high reset
//   baud_select : rate code (see uart_pkg)
//   restart     : restart the divisor from 0 (frame alignment)
//   sample_tick : one-clock strobe every divisor clocks
module baud_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       restart,
  output logic       sample_tick
);

  localparam logic [DIV_W-1:0] DIV_TBL [8] = '{
    DIV_W'(baud_divisor(CLK_FREQ_HZ, 3'd0)),
    DIV_W'(baud_divisor(CLK_FREQ_HZ, 3'd1)),
    DIV_W'(baud_divisor(CLK_FREQ_HZ, 3'd2)),
    DIV_W'(baud_divisor(CLK_FREQ_HZ, 3'd3)),
    DIV_W'(baud_divisor(CLK_FREQ_HZ, 3'd4)),
    DIV_W'(baud_divisor(CLK_FREQ_HZ, 3'd5)),
    DIV_W'(baud_divisor(CLK_FREQ_HZ, 3'd6)),
    DIV_W'(baud_divisor(CLK_FREQ_HZ, 3'd7))
  };

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

  assign last        = DIV_TBL[baud_select] - DIV_W'(1);
  assign sample_tick = (cnt == last);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (cnt >= last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver -- 8E1 UART receiver with runtime-selectable baud rate.
//   clk         : system clock, rising edge
//   reset       : synchronous active-high reset
//   baud_select : rate code, latched at each start detection
//   rx_en       : receiver enable; low holds/aborts to idle
//   rx_d        : asynchronous serial input, idle high
//   rx_data     : last received byte
//   rx_valid    : one-clock pulse when rx_data/status update
//   rx_perror   : even-parity error of the last frame
//   rx_ferror   : framing (stop bit) error of the last frame
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       rx_en,
  input  logic       rx_d,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_perror,
  output logic       rx_ferror
);

  rx_state_e  state_q, state_d;
  logic       rx_s1, rx_s2, line_prev;
  logic       line, fall;
  logic [2:0] baud_q;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       perr_q, perr_d;
  logic       done;
  logic       restart;
  logic       sample_tick;

  assign line = rx_s2;
  // Needs a seen-high line before a new start, so a stuck-low line yields one frame only
  assign fall = line_prev & ~line;

  baud_controller #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_baud (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_q),
    .restart     (restart),
    .sample_tick (sample_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      line_prev <= 1'b1;
      baud_q    <= BAUD_300;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_perror <= 1'b0;
      rx_ferror <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_s1     <= rx_d;
      rx_s2     <= rx_s1;
      line_prev <= line;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      rx_valid  <= done;
      if (restart) begin
        baud_q <= baud_select;
      end
      if (done) begin
        rx_data   <= shift_q;
        rx_perror <= perr_q;
        rx_ferror <= ~line;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    done    = 1'b0;
    restart = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_en && fall) begin
          state_d = START;
          tick_d  = '0;
          bit_d   = '0;
          restart = 1'b1;
        end
      end

      START: begin
        if (sample_tick) begin
          if (tick_q == 4'd7) begin
            // Mid start bit: still low means a real frame, else a glitch
            tick_d  = '0;
            state_d = line ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      DATA: begin
        if (sample_tick) begin
          if (tick_q == 4'd15) begin
            tick_d  = '0;
            shift_d = {line, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = PARITY;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      PARITY: begin
        if (sample_tick) begin
          if (tick_q == 4'd15) begin
            tick_d  = '0;
            perr_d  = (^shift_q) ^ line;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      STOP: begin
        if (sample_tick) begin
          if (tick_q == 4'd15) begin
            // Back to IDLE at mid stop bit so an immediate next start is caught
            tick_d  = '0;
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !rx_en) begin
      state_d = IDLE;
      done    = 1'b0;
    end
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency in Hz used to derive baud divisors.
REQ-002 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 baud_select  input  3  rate code: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200 baud.
REQ-005 rx_en  input  1  receiver enable; low SHALL hold the receiver idle.
REQ-006 rx_d  input  1  asynchronous serial line, idle high.
REQ-007 rx_data  output  8  last received byte.
REQ-008 rx_valid  output  1  one-cycle pulse: new byte and status available.
REQ-009 rx_perror  output  1  parity error status of the last frame.
REQ-010 rx_ferror  output  1  framing error status of the last frame.

Function
REQ-011 Frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
REQ-012 rx_d SHALL pass through a 2-flop synchronizer before any use; all references to the line below mean the synchronized value.
REQ-013 A sample tick SHALL occur every round(CLK_FREQ_HZ/(16*rate)) clocks, giving 16 ticks per bit.
REQ-014 The divisor counter SHALL restart from 0 on start-edge detection so that sampling is frame-aligned.
REQ-015 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: a 1->0 transition of the line with rx_en=1 SHALL move the FSM to START and latch baud_select for the whole frame.
REQ-017 START: at tick 8, a low line SHALL move the FSM to DATA with the tick count reset; a high line is a glitch and SHALL return the FSM to IDLE with no pulse and no status change.
REQ-018 DATA: the line SHALL be sampled at every 16th tick (mid-bit), shifting LSB first; after 8 bits the FSM SHALL go to PARITY.
REQ-019 PARITY: the line SHALL be sampled mid-bit; perror = (XOR of 8 data bits) XOR parity bit.
REQ-020 STOP: the line SHALL be sampled mid-bit; ferror = NOT sampled value; the FSM SHALL return to IDLE on that same cycle so that a back-to-back start bit is accepted.
REQ-021 rx_valid SHALL pulse high for exactly one clk, in the cycle after the stop sample.
REQ-022 rx_data, rx_perror and rx_ferror SHALL update in the same cycle as that pulse and hold until the next pulse or reset.
REQ-023 A byte SHALL be delivered even when perror or ferror is set.
REQ-024 rx_en deasserted mid-frame SHALL abort the frame: the FSM goes to IDLE the next cycle, with no pulse and outputs unchanged.
REQ-025 A baud_select change mid-frame SHALL have no effect until the next start detection.
REQ-026 A line held low continuously SHALL produce at most one frame, with ferror=1, and no new start until the line has been seen high.

Reset
REQ-027 On reset the FSM SHALL be IDLE; rx_data=0x00, rx_valid=0, rx_perror=0, rx_ferror=0; all counters, the shift register and the synchronizer (to 1) SHALL be cleared.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame with no rx_valid pulse.

Structure
REQ-029 A shared package uart_pkg SHALL hold the FSM state enum, the baud-code constants and a function computing the divisor from CLK_FREQ_HZ and the code.
REQ-030 One sub-module, baud_controller (clk, reset, baud_select, restart -> sample_tick), SHALL generate the tick; it is reusable by the transmitter.

Verification
REQ-031 At 9600 baud, send 0xA5 with parity 0 and stop 1: one rx_valid pulse, rx_data=0xA5, perror=0, ferror=0.
REQ-032 Send 0xA5 with parity 1: rx_data=0xA5, perror=1, ferror=0.
REQ-033 Send 0x3C with stop bit 0: ferror=1, rx_data=0x3C.
REQ-034 Drive rx_d low for 4 sample ticks, then high: no rx_valid pulse and outputs unchanged.
REQ-035 At 115200 baud, send 0x12 and 0x34 back-to-back with no idle between frames: two pulses carrying 0x12 then 0x34, no errors.
REQ-036 Assert reset during data bit 4, then send 0x55: no pulse for the aborted frame; one pulse with 0x55 after reset.
